uart_baud_gen: RTL and testbench
================================

# uart_baud_gen

Runtime-programmable UART baud generator with fractional division, an oversample tick, and receiver resynchronisation. It produces a 1-cycle oversample strobe at an average period of div_int + div_frac/2^FRAC_BITS clocks. It also produces a full-bit strobe every OVERSAMPLE oversample ticks and a bit-centre strobe for the receiver's data sampler. It replaces the fixed single-rate tick generator in the UART receiver/transmitter path.

## Interface
Parameters:
- DIV_WIDTH, 14: width of the integer divisor.
- FRAC_BITS, 4: width of the fractional divisor.
- OVERSAMPLE, 16: oversample ticks per bit. Even, ≥4.
- DEFAULT_DIV, 20: integer divisor after reset.
- DEFAULT_FRAC, 0: fractional divisor after reset.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: count enable.
- restart, input, 1: 1-cycle pulse that realigns the bit phase (receiver drives it on start-bit edge).
- div_load, input, 1: 1-cycle pulse that captures div_int_in and div_frac_in.
- div_int_in, input, DIV_WIDTH: new integer divisor.
- div_frac_in, input, FRAC_BITS: new fractional divisor.
- os_tick, output, 1: oversample strobe.
- mid_tick, output, 1: bit-centre strobe.
- baud_tick, output, 1: bit-boundary strobe.

## Operation
- Registers:
  - shadow divisor (sh_int, sh_frac).
  - active divisor (act_int, act_frac).
  - down-counter cnt[DIV_WIDTH].
  - frac_acc[FRAC_BITS].
  - os_cnt[$clog2(OVERSAMPLE)].
- div_load:
  - Shadow captures div_int_in and div_frac_in. An integer value <2 is stored as 2.
  - The shadow copies to active only at a reload or at restart. There is never a mid-period change.
- With en=1, cnt decrements each cycle.
- When cnt==0 (reload):
  - Active divisor is updated from shadow.
  - {carry, frac_acc} ← frac_acc + act_frac, using the updated act_frac.
  - cnt ← act_int − 1 + carry, so that period is stretched by one cycle.
  - os_tick is registered high on the next edge, for exactly one cycle.
- The os_cnt update happens on the same edge os_tick rises:
  - os_cnt increments, wrapping at OVERSAMPLE−1 → 0.
  - baud_tick=1 on that edge if os_cnt was OVERSAMPLE−1.
  - mid_tick=1 on that edge if os_cnt was OVERSAMPLE/2−1.
  - baud_tick and mid_tick are always coincident with os_tick.
- en=0: cnt, frac_acc, and os_cnt hold. All ticks are 0. Counting resumes from the held state.
- restart: this edge sets cnt ← sh_int−1, frac_acc ← 0, os_cnt ← 0, and active ← shadow.
  - All ticks are 0 on that edge, regardless of en.
  - restart has priority over reload.
  - restart together with div_load uses the new div_int_in and div_frac_in.
- Reset:
  - cnt = DEFAULT_DIV−1; sh and act = DEFAULT_DIV / DEFAULT_FRAC.
  - frac_acc = 0, os_cnt = 0.
  - os_tick, mid_tick, and baud_tick are all 0.
  - Reset mid-period aborts immediately. There is no partial tick.

## Timing
- Latency:
  - First os_tick occurs on the act_int-th rising edge after reset release or restart, with en held at 1.
  - Consecutive os_ticks are act_int or act_int+1 cycles apart.
- Relative to reset release or restart:
  - baud_tick first occurs on the OVERSAMPLE-th os_tick.
  - mid_tick first occurs on the (OVERSAMPLE/2)-th os_tick, at half a bit.
- Fractional pattern: over 2^FRAC_BITS reloads, exactly act_frac periods are stretched.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Minimum divisor is 2. os_tick is never high on two consecutive cycles.

## Structure
- Shared package uart_pkg holds:
  - DIV_WIDTH, FRAC_BITS, and OVERSAMPLE defaults.
  - MIN_DIV = 2.
  - The reset divisor constants, shared with uart_receiver and uart_transmitter.
- Single module. The fractional accumulator is small enough to stay inline, so there is no sub-module.

## Test plan
- Reset, en=1, div 20/0, OVERSAMPLE=16:
  - os_tick at edges 20, 40, 60, …
  - mid_tick at edge 160.
  - baud_tick at edge 320.
  - No tick on any other edge.
- div_load 10/8 (FRAC_BITS=4) then restart:
  - os_tick spacings are 10, 10, 11, 10, 11, 10, 11, …
  - 32 reloads contain exactly 16 stretched periods.
- div_load 40/0 at cnt=5 under div 20:
  - The current period still ends at 20 cycles.
  - The next period is 40 cycles.
  - Loading div_int_in 0 or 1 yields a 2-cycle period.
- restart at os_cnt=11 mid-period:
  - No tick on the restart edge.
  - Next os_tick is act_int cycles later.
  - mid_tick follows 8 os_ticks after restart.
  - restart together with div_load uses the new value.
- en low for 7 cycles at cnt=3: ticks stay 0, and the next os_tick arrives 7 cycles later than without the pause.
- Assert rst asynchronously between edges mid-bit:
  - Outputs go to 0 immediately.
  - After release, the first os_tick is at edge DEFAULT_DIV.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Constants shared by the UART path (baud generator, receiver, transmitter).
//   Holds the default divisor geometry, the smallest legal integer divisor
//   and the divisor loaded at reset, so all three blocks come out of reset
//   agreeing on the line rate.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Default geometry of the baud divisor.
    localparam int UART_DIV_WIDTH  = 14;
    localparam int UART_FRAC_BITS  = 4;
    localparam int UART_OVERSAMPLE = 16;

    // Smallest integer divisor; guarantees os_tick never fires on two
    // consecutive cycles.
    localparam int MIN_DIV = 2;

    // Divisor in force after reset.
    localparam int UART_DEFAULT_DIV  = 20;
    localparam int UART_DEFAULT_FRAC = 0;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Runtime-programmable fractional baud generator. Emits a 1-cycle oversample
//   strobe whose average period is div_int + div_frac/2^FRAC_BITS clocks, a
//   bit-boundary strobe every OVERSAMPLE oversample strobes and a bit-centre
//   strobe half a bit after each boundary. A restart pulse realigns the bit
//   phase (receiver start-bit edge).
//
// Ports
//   clk         : clock
//   rst         : asynchronous active-high reset
//   en          : count enable; when low all state holds and ticks are 0
//   restart     : 1-cycle pulse, realigns period and bit phase
//   div_load    : 1-cycle pulse, captures div_int_in/div_frac_in into shadow
//   div_int_in  : new integer divisor (values below 2 are stored as 2)
//   div_frac_in : new fractional divisor (in 1/2^FRAC_BITS clock units)
//   os_tick     : oversample strobe (registered)
//   mid_tick    : bit-centre strobe, coincident with an os_tick (registered)
//   baud_tick   : bit-boundary strobe, coincident with an os_tick (registered)
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH    = UART_DIV_WIDTH,
    parameter int FRAC_BITS    = UART_FRAC_BITS,
    parameter int OVERSAMPLE   = UART_OVERSAMPLE,
    parameter int DEFAULT_DIV  = UART_DEFAULT_DIV,
    parameter int DEFAULT_FRAC = UART_DEFAULT_FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 restart,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_int_in,
    input  logic [FRAC_BITS-1:0] div_frac_in,
    output logic                 os_tick,
    output logic                 mid_tick,
    output logic                 baud_tick
);

    localparam int OS_W = $clog2(OVERSAMPLE);

    localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]      OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN  = DIV_WIDTH'(MIN_DIV);

    // Shadow divisor (written by div_load) and active divisor (in force for
    // the current period).
    logic [DIV_WIDTH-1:0] sh_int_reg,   sh_int_next;
    logic [FRAC_BITS-1:0] sh_frac_reg,  sh_frac_next;
    logic [DIV_WIDTH-1:0] act_int_reg,  act_int_next;
    logic [FRAC_BITS-1:0] act_frac_reg, act_frac_next;

    // Period down-counter, fractional phase accumulator, oversample index.
    logic [DIV_WIDTH-1:0] cnt_reg,      cnt_next;
    logic [FRAC_BITS-1:0] frac_acc_reg, frac_acc_next;
    logic [OS_W-1:0]      os_cnt_reg,   os_cnt_next;

    logic os_tick_reg,   os_tick_next;
    logic mid_tick_reg,  mid_tick_next;
    logic baud_tick_reg, baud_tick_next;

    logic [DIV_WIDTH-1:0] load_int;
    logic [FRAC_BITS:0]   frac_sum;
    logic                 reload;

    always_comb begin
        // Clamp tiny divisors so the strobe can never run back-to-back.
        load_int = (div_int_in < DIV_MIN) ? DIV_MIN : div_int_in;

        sh_int_next  = sh_int_reg;
        sh_frac_next = sh_frac_reg;
        if (div_load) begin
            sh_int_next  = load_int;
            sh_frac_next = div_frac_in;
        end

        // restart wins over a coincident terminal count.
        reload = en && (cnt_reg == '0) && !restart;

        // restart takes the freshly loaded value when both pulse together;
        // a plain reload takes whatever the shadow held before this edge.
        act_int_next  = act_int_reg;
        act_frac_next = act_frac_reg;
        if (restart) begin
            act_int_next  = sh_int_next;
            act_frac_next = sh_frac_next;
        end else if (reload) begin
            act_int_next  = sh_int_reg;
            act_frac_next = sh_frac_reg;
        end

        // Carry out of the accumulator stretches the new period by one clock.
        frac_sum = {1'b0, frac_acc_reg} + {1'b0, act_frac_next};

        cnt_next       = cnt_reg;
        frac_acc_next  = frac_acc_reg;
        os_cnt_next    = os_cnt_reg;
        os_tick_next   = 1'b0;
        mid_tick_next  = 1'b0;
        baud_tick_next = 1'b0;

        if (restart) begin
            cnt_next      = sh_int_next - DIV_ONE;
            frac_acc_next = '0;
            os_cnt_next   = '0;
        end else if (reload) begin
            cnt_next       = act_int_next - DIV_ONE + DIV_WIDTH'(frac_sum[FRAC_BITS]);
            frac_acc_next  = frac_sum[FRAC_BITS-1:0];
            os_cnt_next    = (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + OS_W'(1);
            os_tick_next   = 1'b1;
            mid_tick_next  = (os_cnt_reg == OS_MID);
            baud_tick_next = (os_cnt_reg == OS_LAST);
        end else if (en) begin
            cnt_next = cnt_reg - DIV_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_int_reg    <= DIV_WIDTH'(DEFAULT_DIV);
            sh_frac_reg   <= FRAC_BITS'(DEFAULT_FRAC);
            act_int_reg   <= DIV_WIDTH'(DEFAULT_DIV);
            act_frac_reg  <= FRAC_BITS'(DEFAULT_FRAC);
            cnt_reg       <= DIV_WIDTH'(DEFAULT_DIV - 1);
            frac_acc_reg  <= '0;
            os_cnt_reg    <= '0;
            os_tick_reg   <= 1'b0;
            mid_tick_reg  <= 1'b0;
            baud_tick_reg <= 1'b0;
        end else begin
            sh_int_reg    <= sh_int_next;
            sh_frac_reg   <= sh_frac_next;
            act_int_reg   <= act_int_next;
            act_frac_reg  <= act_frac_next;
            cnt_reg       <= cnt_next;
            frac_acc_reg  <= frac_acc_next;
            os_cnt_reg    <= os_cnt_next;
            os_tick_reg   <= os_tick_next;
            mid_tick_reg  <= mid_tick_next;
            baud_tick_reg <= baud_tick_next;
        end
    end

    assign os_tick   = os_tick_reg;
    assign mid_tick  = mid_tick_reg;
    assign baud_tick = baud_tick_reg;

endmodule : uart_baud_gen

// File: tb/tb_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen
//   Scoreboard bench for uart_baud_gen with default parameters
//   (div 20/0, FRAC_BITS=4, OVERSAMPLE=16). Each stimulus step pushes the
//   cycles at which os_tick must fire (with the expected mid/baud flags);
//   a monitor pops and compares every tick, and flags stray or missing ticks.
// -----------------------------------------------------------------------------
module tb_uart_baud_gen;

    localparam int OS = 16;

    typedef struct {
        int cyc;
        bit mid;
        bit baud;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        restart;
    logic        div_load;
    logic [13:0] div_int_in;
    logic [3:0]  div_frac_in;
    logic        os_tick;
    logic        mid_tick;
    logic        baud_tick;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    int   obs[$];

    uart_baud_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .restart     (restart),
        .div_load    (div_load),
        .div_int_in  (div_int_in),
        .div_frac_in (div_frac_in),
        .os_tick     (os_tick),
        .mid_tick    (mid_tick),
        .baud_tick   (baud_tick)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    // k is the tick index since the last reset/restart (1-based).
    task automatic push_exp(input int c, input int k);
        exp_t e;
        e.cyc  = c;
        e.mid  = ((k % OS) == OS / 2);
        e.baud = ((k % OS) == 0);
        sb.push_back(e);
    endtask

    // Drive a one-cycle pulse so that it is sampled by rising edge e.
    // Must be called from a falling edge.
    task automatic pulse(input int e, input bit rs, input bit ld, input int di, input int df);
        if (cyc > e - 1) check_eq("sched", cyc, e - 1);
        while (cyc < e - 1) @(negedge clk);
        restart     = rs;
        div_load    = ld;
        div_int_in  = 14'(di);
        div_frac_in = 4'(df);
        @(negedge clk);
        restart  = 1'b0;
        div_load = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: one line per observed tick, compared against the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        #1;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check_eq("tick_late", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (os_tick || mid_tick || baud_tick) begin
            if (os_tick) obs.push_back(cyc);
            $display("tick cyc=%0d os=%0b mid=%0b baud=%0b", cyc, os_tick, mid_tick, baud_tick);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check_eq("os", int'(os_tick), 1);
                check_eq("mid", int'(mid_tick), int'(e.mid));
                check_eq("baud", int'(baud_tick), int'(e.baud));
            end else begin
                check_eq("stray_tick", int'({os_tick, mid_tick, baud_tick}), 0);
            end
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            void'(sb.pop_front());
            check_eq("os_missing", int'(os_tick), 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, e1, e3, e4, f, g, h, r2, t, acc, c, n, base;

        rst = 1'b0; en = 1'b1; restart = 1'b0; div_load = 1'b0;
        div_int_in = '0; div_frac_in = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_os", int'(os_tick), 0);
        check_eq("rst_mid", int'(mid_tick), 0);
        check_eq("rst_baud", int'(baud_tick), 0);

        // Default divisor straight out of reset: ticks every 20 edges,
        // mid at 160, baud at 320.
        rst = 1'b0;
        r = cyc;
        for (int k = 1; k <= 20; k++) push_exp(r + 20 * k, k);

        // Fractional divisor 10 + 8/16, realigned by restart.
        pulse(r + 401, 1'b0, 1'b1, 10, 8);
        base = obs.size();
        e1 = r + 402;
        t = e1 + 10;
        push_exp(t, 1);
        acc = 0;
        for (int k = 1; k <= 32; k++) begin
            acc += 8;
            c = (acc >= 16) ? 1 : 0;
            if (c != 0) acc -= 16;
            t += 10 + c;
            push_exp(t, k + 1);
        end
        pulse(e1, 1'b1, 1'b0, 0, 0);

        // Back to 20 via restart+load; load 40 at cnt=5; then load 0.
        e3 = t + 1;
        push_exp(e3 + 20, 1);
        push_exp(e3 + 40, 2);
        push_exp(e3 + 60, 3);
        push_exp(e3 + 100, 4);
        push_exp(e3 + 140, 5);
        for (int k = 6; k <= 16; k++) push_exp(e3 + 180 + 2 * (k - 6), k);
        pulse(e3, 1'b1, 1'b1, 20, 0);

        // 32 reloads after the first fractional tick: exactly 16 stretched.
        n = 0;
        check_eq("p2_ticks", obs.size() - base, 33);
        if (obs.size() >= base + 33) begin
            for (int i = 0; i < 32; i++)
                if (obs[base + i + 1] - obs[base + i] == 11) n++;
        end
        check_eq("stretched", n, 16);

        pulse(e3 + 55, 1'b0, 1'b1, 40, 0);
        pulse(e3 + 150, 1'b0, 1'b1, 0, 0);

        // Restart mid-period at os_cnt=11, then restart on a reload edge
        // together with a load of 1.
        e4 = e3 + 201;
        for (int k = 1; k <= 11; k++) push_exp(e4 + 20 * k, k);
        pulse(e4, 1'b1, 1'b1, 20, 0);
        f = e4 + 227;
        for (int k = 1; k <= 9; k++) push_exp(f + 20 * k, k);
        pulse(f, 1'b1, 1'b0, 0, 0);
        g = f + 200;
        for (int k = 1; k <= 10; k++) push_exp(g + 2 * k, k);
        pulse(g, 1'b1, 1'b1, 1, 0);

        // en low for 7 edges with cnt=3: third tick slips from +60 to +67.
        h = g + 21;
        push_exp(h + 20, 1);
        push_exp(h + 40, 2);
        push_exp(h + 67, 3);
        push_exp(h + 87, 4);
        pulse(h, 1'b1, 1'b1, 20, 0);
        wait_cyc(h + 56);
        en = 1'b0;
        wait_cyc(h + 63);
        en = 1'b1;

        // Asynchronous reset while os_tick is high.
        wait_cyc(h + 86);
        @(posedge clk);
        #2;
        check_eq("os_pre_rst", int'(os_tick), 1);
        rst = 1'b1;
        #1;
        check_eq("os_async_rst", int'(os_tick), 0);
        check_eq("mid_async_rst", int'(mid_tick), 0);
        check_eq("baud_async_rst", int'(baud_tick), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r2 = cyc;
        push_exp(r2 + 20, 1);
        push_exp(r2 + 40, 2);
        wait_cyc(r2 + 45);

        check_eq("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_baud_gen
